// File: rtl/cordic_pkg.sv
// Purpose: shared types and constants for the CORDIC result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cordic_pkg;

    localparam int FIXED_W_DEF = 23;
    localparam int FRAC_W_DEF  = 21;
    localparam int FP_EXP_BIAS = 127;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        PACK
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
    } float_t;

endpackage

// File: rtl/cordic_fixed_to_float_if.sv
// Purpose: start/done handshake and data bus between the control logic and the converter.
// Latency: n/a (wiring only).
// Backpressure: none; the requester waits for done before issuing the next start.
// Signals: start, fixedPoint_in (requester -> converter); done, float_result (converter -> requester).
interface cordic_fixed_to_float_if #(
    parameter int FIXED_W = cordic_pkg::FIXED_W_DEF
);
    logic               start;
    logic [FIXED_W-1:0] fixedPoint_in;
    logic               done;
    logic [31:0]        float_result;

    modport master (
        output start,
        output fixedPoint_in,
        input  done,
        input  float_result
    );

    modport slave (
        input  start,
        input  fixedPoint_in,
        output done,
        output float_result
    );
endinterface

// File: rtl/cordic_fixed_to_float.sv
// Purpose: serial converter from signed fixed-point CORDIC output to IEEE-754 single.
// Latency: s+2 enabled edges for nonzero input (s = leading zeros below the MSB), 1 for zero.
// Backpressure: start only accepted in IDLE; anything else is dropped, all updates gated by clk_en.
// Ports: clk, reset (sync, active-high), clk_en; bus (slave): start, fixedPoint_in, done, float_result.
module cordic_fixed_to_float
    import cordic_pkg::*;
#(
    parameter int FIXED_W = FIXED_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_en,
    cordic_fixed_to_float_if.slave  bus
);

    // Exponent when the leading one already sits in the MSB of mag.
    localparam int EXP_BASE = FP_EXP_BIAS + FIXED_W - 1 - FRAC_W;

    state_t             state_q, state_d;
    logic [FIXED_W-1:0] mag_q, mag_d;
    logic [4:0]         s_q, s_d;
    logic               sign_q, sign_d;
    logic               done_q, done_d;
    float_t             result_q, result_d;

    logic [FIXED_W-1:0] in_mag;
    logic [7:0]         pack_exp;
    logic [22:0]        pack_frac;

    // The most negative input negates to 2^(FIXED_W-1), which is still
    // representable as an unsigned FIXED_W-bit magnitude.
    assign in_mag = bus.fixedPoint_in[FIXED_W-1] ? (~bus.fixedPoint_in + FIXED_W'(1))
                                                 : bus.fixedPoint_in;

    assign pack_exp = 8'(EXP_BASE - int'(s_q));

    // Left-align mag into 24 bits so the hidden one lands on bit 23 and
    // the remaining bits form the zero-padded fraction.
    assign pack_frac = 23'(24'(mag_q) << (24 - FIXED_W));

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        s_d      = s_q;
        sign_d   = sign_q;
        done_d   = 1'b0;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d  = bus.fixedPoint_in[FIXED_W-1];
                    mag_d   = in_mag;
                    s_d     = 5'd0;
                    state_d = (in_mag == '0) ? PACK : NORM;
                end
            end
            NORM: begin
                if (!mag_q[FIXED_W-1]) begin
                    mag_d = mag_q << 1;
                    s_d   = s_q + 5'd1;
                end else begin
                    state_d = PACK;
                end
            end
            PACK: begin
                done_d  = 1'b1;
                state_d = IDLE;
                // Zero bypasses the sign so -0.0 is never produced.
                if (mag_q == '0) begin
                    result_d = '0;
                end else begin
                    result_d.sign = sign_q;
                    result_d.exp  = pack_exp;
                    result_d.frac = pack_frac;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            s_q      <= '0;
            sign_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            s_q      <= s_d;
            sign_q   <= sign_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign bus.done         = done_q;
    assign bus.float_result = result_q;

endmodule

// File: tb/tb_cordic_fixed_to_float.sv
module tb_cordic_fixed_to_float;
    import cordic_pkg::*;

    localparam int W = FIXED_W_DEF;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;

    always #5 clk = ~clk;

    cordic_fixed_to_float_if #(.FIXED_W(W)) bus ();

    cordic_fixed_to_float #(
        .FIXED_W(W),
        .FRAC_W (FRAC_W_DEF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clk_en(clk_en),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference conversion: locate the leading one, build the float from it.
    function automatic exp_t model(input logic [22:0] v);
        exp_t e;
        int   mag;
        int   p;
        if (v == 23'd0) begin
            e.res = 32'h0;
            e.lat = 1;
            return e;
        end
        mag = v[22] ? ((1 << 23) - int'(v)) : int'(v);
        p = 0;
        for (int i = 0; i < 24; i++) if (mag[i]) p = i;
        e.res[31]    = v[22];
        e.res[30:23] = 8'(127 + p - 21);
        e.res[22:0]  = 23'((mag - (1 << p)) << (23 - p));
        e.lat        = 24 - p;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic drive_start(input logic [22:0] v, input logic [31:0] res, input int lat);
        exp_t e;
        e.res = res;
        e.lat = lat;
        bus.start         = 1'b1;
        bus.fixedPoint_in = v;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        bus.start         = 1'b0;
        bus.fixedPoint_in = 23'($urandom);
    endtask

    // Counts clock cycles until done is seen, bounded by budget.
    task automatic wait_done(input int budget, output int lat, output bit ok);
        lat = 0;
        while (bus.done !== 1'b1 && lat < budget) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        ok = (bus.done === 1'b1);
    endtask

    task automatic test_reset();
        reset             = 1'b1;
        clk_en            = 1'b0;
        bus.start         = 1'b1;
        bus.fixedPoint_in = 23'h200000;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b want 0", bus.done);
        end
        vectors++;
        if (bus.float_result !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_result: got %h want 00000000", bus.float_result);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        clk_en    = 1'b1;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_dropped: done=%b want 0", bus.done);
        end
    endtask

    task automatic test_convert();
        logic [22:0] vin [5] = '{23'h200000, 23'h400000, 23'h600000, 23'h180000, 23'h000001};
        logic [31:0] vres[5] = '{32'h3F800000, 32'hC0000000, 32'hBF800000, 32'h3F400000, 32'h35000000};
        int          vlat[5] = '{3, 2, 3, 4, 24};
        exp_t e;
        int   lat;
        bit   ok;
        for (int i = 0; i < 5; i++) begin
            drive_start(vin[i], vres[i], vlat[i]);
            wait_done(40, lat, ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || lat != e.lat) begin
                miscompares++;
                $display("FAIL convert_latency in=%h: got %0d (done=%b) want %0d", vin[i], lat, ok, e.lat);
            end
            vectors++;
            if (bus.float_result !== e.res) begin
                miscompares++;
                $display("FAIL convert_result in=%h: got %h want %h", vin[i], bus.float_result, e.res);
            end
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bus.done !== 1'b0) begin
                miscompares++;
                $display("FAIL convert_done_pulse in=%h: done=%b want 0", vin[i], bus.done);
            end
        end
    endtask

    task automatic test_zero_and_ignore();
        exp_t e;
        int   lat;
        int   extra;
        bit   ok;
        drive_start(23'h000000, 32'h0, 1);
        wait_done(40, lat, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || lat != e.lat || bus.float_result !== e.res) begin
            miscompares++;
            $display("FAIL zero: lat %0d res %h (done=%b) want lat %0d res %h", lat, bus.float_result, ok, e.lat, e.res);
        end
        @(posedge clk);
        @(negedge clk);
        // Second start lands mid-normalisation and must be dropped.
        drive_start(23'h000001, 32'h35000000, 24);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        bus.start         = 1'b1;
        bus.fixedPoint_in = 23'h200000;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(40, lat, ok);
        lat += 4;
        e = sb.pop_front();
        vectors++;
        if (!ok || lat != e.lat || bus.float_result !== e.res) begin
            miscompares++;
            $display("FAIL ignore_start: lat %0d res %h (done=%b) want lat %0d res %h", lat, bus.float_result, ok, e.lat, e.res);
        end
        extra = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL ignore_extra_done: got %0d extra pulses want 0", extra);
        end
    endtask

    task automatic test_clk_en();
        exp_t e;
        int   lat;
        bit   ok;
        drive_start(23'h100000, 32'h3F000000, 7);
        @(posedge clk);
        @(negedge clk);
        clk_en = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        clk_en = 1'b1;
        wait_done(40, lat, ok);
        lat += 4;
        e = sb.pop_front();
        vectors++;
        if (!ok || lat != e.lat) begin
            miscompares++;
            $display("FAIL stall_latency: got %0d (done=%b) want %0d", lat, ok, e.lat);
        end
        vectors++;
        if (bus.float_result !== e.res) begin
            miscompares++;
            $display("FAIL stall_result: got %h want %h", bus.float_result, e.res);
        end
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            vectors++;
            if (bus.done !== 1'b1 || bus.float_result !== e.res) begin
                miscompares++;
                $display("FAIL stall_done_hold cyc %0d: done=%b res=%h want 1 %h", k, bus.done, bus.float_result, e.res);
            end
        end
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done_fall: done=%b want 0", bus.done);
        end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   lat;
        int   extra;
        bit   ok;
        drive_start(23'h000001, 32'h35000000, 24);
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (bus.done !== 1'b0 || bus.float_result !== 32'h0) begin
            miscompares++;
            $display("FAIL abort_clear: done=%b res=%h want 0 00000000", bus.done, bus.float_result);
        end
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL abort_no_done: got %0d pulses want 0", extra);
        end
        drive_start(23'h200000, 32'h3F800000, 3);
        wait_done(40, lat, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || lat != e.lat || bus.float_result !== e.res) begin
            miscompares++;
            $display("FAIL abort_restart: lat %0d res %h (done=%b) want lat %0d res %h", lat, bus.float_result, ok, e.lat, e.res);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [22:0] v;
        exp_t        m;
        exp_t        e;
        int          lat;
        bit          ok;
        for (int i = 0; i < 8; i++) begin
            v = 23'($urandom_range(1, 23'h7FFFFF));
            m = model(v);
            // Issued on the negedge where done is still high from the previous job.
            drive_start(v, m.res, m.lat);
            if (i > 0) begin
                vectors++;
                if (bus.done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_done_clear in=%h: done=%b want 0", v, bus.done);
                end
            end
            wait_done(40, lat, ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || lat != e.lat || bus.float_result !== e.res) begin
                miscompares++;
                $display("FAIL b2b in=%h: lat %0d res %h (done=%b) want lat %0d res %h", v, lat, bus.float_result, ok, e.lat, e.res);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_convert();
        test_zero_and_ignore();
        test_clk_en();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
